scan_detect_ctrl: RTL

Parametrised multi-scale, multi-detection scan controller for the Haar-cascade face detector. It generalises the single-result detection flow in four ways: a configurable window stride, a configurable number of window scales, early-exit stage sequencing, and an output FIFO that can hold several detections. It sits between the integral-image unit and the stage evaluator. It sweeps every window position at every scale, requests cascade stages one at a time, and queues each accepted window on a valid/ready stream.

---
 rtl/scan_detect_ctrl_if.sv | 48 ++++
 rtl/scan_detect_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_detect_ctrl_if.sv
// scan_detect_ctrl_if
//   Groups the handshake and bus signals of the scan controller: the
//   integral-image request, the stage request/result pair with the window
//   being evaluated, and the detection output stream.
//
//   Handshake semantics:
//     - ii_start / ii_done: one-cycle request; ii_done may be a level or a pulse.
//     - stage_start / stage_done: one-cycle request; one-cycle result strobe,
//       with stage_passed qualified by stage_done.
//     - det_valid / det_ready: an entry transfers on every rising edge where
//       both are high. det_valid never depends on det_ready. The head entry
//       (det_x, det_y, det_scale) is stable while det_valid is high and
//       det_ready is low.
//
//   Modports:
//     master - the controller (drives requests and the detection stream)
//     slave  - the environment (integral unit, stage evaluator, consumer)
interface scan_detect_ctrl_if;
  logic       ii_start;
  logic       ii_done;
  logic       stage_start;
  logic [7:0] stage_idx;
  logic [7:0] window_x;
  logic [7:0] window_y;
  logic [7:0] window_scale;
  logic [7:0] window_size;
  logic       stage_done;
  logic       stage_passed;
  logic       det_valid;
  logic       det_ready;
  logic [7:0] det_x;
  logic [7:0] det_y;
  logic [7:0] det_scale;

  modport master (
    output ii_start, stage_start, stage_idx,
    output window_x, window_y, window_scale, window_size,
    output det_valid, det_x, det_y, det_scale,
    input  ii_done, stage_done, stage_passed, det_ready
  );

  modport slave (
    input  ii_start, stage_start, stage_idx,
    input  window_x, window_y, window_scale, window_size,
    input  det_valid, det_x, det_y, det_scale,
    output ii_done, stage_done, stage_passed, det_ready
  );
endinterface

// File: rtl/scan_detect_ctrl.sv
// scan_detect_ctrl
//   Multi-scale, multi-detection window scan controller for a Haar-cascade
//   face detector. Per frame it requests an integral-image build, then sweeps
//   every window position (x fastest, then y, then scale), requests cascade
//   stages one at a time with early exit on the first failing stage, and
//   queues every fully accepted window in a first-word-fall-through FIFO.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-low reset (0 = reset)
//     start      begin a frame, honoured only in IDLE
//     bus        scan_detect_ctrl_if.master (ii, stage and detection handshakes)
//     det_count  windows accepted this frame, saturating
//     overflow   sticky, a detection was dropped because the FIFO was full
//     busy       high in every state except IDLE
//     done       one-cycle pulse at the end of the frame
//     dbg_state  current FSM state encoding
module scan_detect_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int WIN_BASE   = 24,
  parameter int SCALE_INC  = 8,
  parameter int NUM_SCALES = 4,
  parameter int STEP       = 2,
  parameter int NUM_STAGES = 25,
  parameter int DET_DEPTH  = 8,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  scan_detect_ctrl_if.master  bus,
  output logic [CNT_W-1:0]    det_count,
  output logic                overflow,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_PUSH  = 3'd5,
    S_ADV   = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  localparam int               PTR_W      = $clog2(DET_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT   = DET_DEPTH[PTR_W:0];
  localparam logic [7:0]       LAST_STAGE = 8'(NUM_STAGES - 1);

  state_t      state;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  scale;
  logic [7:0]  stage;
  logic [7:0]  size;
  logic        ii_start_r;
  logic        stage_start_r;

  // Window side for the current scale, held wide so a large scale index
  // cannot wrap around and slip under the image bounds.
  logic [15:0] size_calc;
  logic        setup_stop;

  assign size_calc  = 16'(WIN_BASE) + 16'(scale) * 16'(SCALE_INC);
  assign setup_stop = ({8'd0, scale} == 16'(NUM_SCALES)) ||
                      (size_calc > 16'(IMG_WIDTH)) ||
                      (size_calc > 16'(IMG_HEIGHT));

  // Next-position arithmetic at 9 bits; size never exceeds the image here
  // because SETUP already rejected oversized scales.
  logic [8:0] lim_x;
  logic [8:0] lim_y;
  logic [8:0] nx;
  logic [8:0] ny;
  logic       wrap_x;
  logic       wrap_y;

  always_comb begin
    lim_x  = 9'(IMG_WIDTH)  - {1'b0, size};
    lim_y  = 9'(IMG_HEIGHT) - {1'b0, size};
    nx     = {1'b0, x} + 9'(STEP);
    wrap_x = nx > lim_x;
    ny     = wrap_x ? ({1'b0, y} + 9'(STEP)) : {1'b0, y};
    wrap_y = ny > lim_y;
  end

  // Detection FIFO
  logic [23:0]      mem [DET_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fcount;
  logic             fifo_full;
  logic             pop;
  logic             wr_en;

  assign fifo_full = (fcount == FULL_CNT);
  assign pop       = (fcount != '0) && bus.det_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en     = (state == S_PUSH) && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {x, y, scale};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fcount <= fcount + 1'b1;
        2'b01:   fcount <= fcount - 1'b1;
        default: ;
      endcase
    end
  end

  // Controller FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      scale         <= '0;
      stage         <= '0;
      size          <= '0;
      ii_start_r    <= 1'b0;
      stage_start_r <= 1'b0;
      det_count     <= '0;
      overflow      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      ii_start_r    <= 1'b0;
      stage_start_r <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x          <= '0;
            y          <= '0;
            scale      <= '0;
            stage      <= '0;
            det_count  <= '0;
            overflow   <= 1'b0;
            ii_start_r <= 1'b1;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.ii_done) state <= S_SETUP;
        end
        S_SETUP: begin
          size <= size_calc[7:0];
          if (setup_stop) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            stage         <= '0;
            stage_start_r <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.stage_done) begin
            if (!bus.stage_passed) begin
              state <= S_ADV;
            end else if (stage == LAST_STAGE) begin
              state <= S_PUSH;
            end else begin
              stage         <= stage + 1'b1;
              stage_start_r <= 1'b1;
              state         <= S_REQ;
            end
          end
        end
        S_PUSH: begin
          if (det_count != '1) det_count <= det_count + 1'b1;
          if (fifo_full && !pop) overflow <= 1'b1;
          state <= S_ADV;
        end
        S_ADV: begin
          stage <= '0;
          x     <= wrap_x ? 8'd0 : nx[7:0];
          y     <= wrap_y ? 8'd0 : ny[7:0];
          if (wrap_y) begin
            scale <= scale + 1'b1;
            state <= S_SETUP;
          end else begin
            stage_start_r <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ii_start     = ii_start_r;
  assign bus.stage_start  = stage_start_r;
  assign bus.stage_idx    = stage;
  assign bus.window_x     = x;
  assign bus.window_y     = y;
  assign bus.window_scale = scale;
  assign bus.window_size  = size;

  assign bus.det_valid = (fcount != '0);
  assign {bus.det_x, bus.det_y, bus.det_scale} = bus.det_valid ? mem[rd_ptr] : 24'd0;

  assign dbg_state = state;

endmodule
